// File: rtl/ap_seq_pkg.sv
// Shared types and default widths for the ap_ctrl_hs sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ap_seq_pkg;

  localparam int DEF_CNT_W        = 16;
  localparam int DEF_LAT_W        = 32;
  localparam int DEF_MAX_INFLIGHT = 2;
  localparam int GAP_W            = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } seq_state_t;

endpackage

// File: rtl/ap_ctrl_sequencer_if.sv
// Block-level ap_ctrl_hs handshake between a sequencer (master) and an HLS kernel (slave).
// Latency: wires only.
// Backpressure: kernel throttles starts with ap_ready; sequencer gates completions with ap_continue.
interface ap_ctrl_sequencer_if;

  logic ap_start;
  logic ap_ready;
  logic ap_done;
  logic ap_continue;

  modport master (
    output ap_start,
    output ap_continue,
    input  ap_ready,
    input  ap_done
  );

  modport slave (
    input  ap_start,
    input  ap_continue,
    output ap_ready,
    output ap_done
  );

endinterface

// File: rtl/ap_seq_ts_fifo.sv
// Start-timestamp FIFO, one entry per in-flight kernel invocation, oldest at the head.
// Latency: head is combinational from storage; a push is visible at the head the cycle after.
// Backpressure: push ignored when full unless a pop frees a slot that cycle; pop ignored when empty.
module ap_seq_ts_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // Pointer advance with explicit wrap so non-power-of-two depths also index safely.
  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign pop_dat = mem[rd_ptr];

  // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage write; contents need no reset because occupancy guards every read.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/ap_ctrl_sequencer.sv
// Issues a configured run of ap_ctrl_hs kernel invocations and measures start-to-done latency.
// Latency: ap_start registered, high the cycle after cfg_start; lat_valid the cycle after the done edge.
// Backpressure: ap_start held until ap_ready; new starts stall on the gap counter or the in-flight limit.
module ap_ctrl_sequencer
  import ap_seq_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int LAT_W        = DEF_LAT_W,
  parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cfg_start,
  input  logic [CNT_W-1:0]     cfg_num_txn,
  input  logic [GAP_W-1:0]     cfg_gap,
  output logic                 busy,
  output logic                 finish,
  output logic                 err,
  ap_ctrl_sequencer_if.master  ap,
  output logic [CNT_W-1:0]     txn_started,
  output logic [CNT_W-1:0]     txn_done,
  output logic                 lat_valid,
  output logic [LAT_W-1:0]     lat_value,
  output logic [LAT_W-1:0]     lat_max
);

  localparam int              IF_W     = $clog2(MAX_INFLIGHT + 1);
  localparam logic [IF_W-1:0] INFL_LIM = IF_W'(MAX_INFLIGHT);

  seq_state_t       state;
  seq_state_t       state_nxt;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] started_q;
  logic [CNT_W-1:0] done_q;
  logic [CNT_W-1:0] started_nxt;
  logic [CNT_W-1:0] done_nxt;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_cnt;
  logic [GAP_W-1:0] gap_nxt;
  logic [IF_W-1:0]  inflight;
  logic [IF_W-1:0]  inflight_nxt;
  logic [LAT_W-1:0] cycle_cnt;
  logic [LAT_W-1:0] ts_head;
  logic [LAT_W-1:0] lat_cur;
  logic             start_q;
  logic             start_nxt;
  logic             cont;
  logic             accept;
  logic             done_seen;
  logic             cmpl;
  logic             spurious;
  logic             fifo_empty;
  logic             fifo_full;

  // A done only counts while ap_continue is high; with nothing in flight it is flagged, not counted.
  assign accept    = (state == RUN) & start_q & ap.ap_ready;
  assign done_seen = cont & ap.ap_done;
  assign cmpl      = done_seen & ~fifo_empty;
  assign spurious  = done_seen & fifo_empty;
  assign lat_cur   = cycle_cnt - ts_head;

  assign ap.ap_start    = start_q;
  assign ap.ap_continue = cont;
  assign txn_started    = started_q;
  assign txn_done       = done_q;

  ap_seq_ts_fifo #(
    .DEPTH (MAX_INFLIGHT),
    .WIDTH (LAT_W)
  ) u_ts_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (accept & (~fifo_full | cmpl)),
    .push_dat (cycle_cnt),
    .pop      (cmpl),
    .pop_dat  (ts_head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  // Post-edge counter values; the gap counter reloads on accept and otherwise runs down to zero.
  always_comb begin
    started_nxt  = started_q + CNT_W'(accept);
    done_nxt     = done_q + CNT_W'(cmpl);
    inflight_nxt = inflight + IF_W'(accept) - IF_W'(cmpl);
    gap_nxt      = gap_cnt;
    if (accept) begin
      gap_nxt = gap_q;
    end else if (gap_cnt != '0) begin
      gap_nxt = gap_cnt - 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state; transitions look at post-edge counts so FINISH follows the last done by one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_start) state_nxt = (cfg_num_txn == '0) ? FINISH : RUN;
      RUN:     if (started_nxt == num_q) state_nxt = DRAIN;
      DRAIN:   if (done_nxt == num_q) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy   = (state != IDLE);
    finish = (state == FINISH);
    cont   = (state == RUN) || (state == DRAIN);
  end

  // ap_start for the next cycle: eligible once the gap has expired and a slot is free.
  always_comb begin
    start_nxt = 1'b0;
    if (state == IDLE) begin
      start_nxt = cfg_start && (cfg_num_txn != '0);
    end else if (state_nxt == RUN) begin
      start_nxt = (started_nxt < num_q) && (inflight_nxt < INFL_LIM) && (gap_nxt == '0);
    end
  end

  // Run configuration, counters, error flag and latency capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_cnt <= '0;
      start_q   <= 1'b0;
      num_q     <= '0;
      gap_q     <= '0;
      gap_cnt   <= '0;
      started_q <= '0;
      done_q    <= '0;
      inflight  <= '0;
      err       <= 1'b0;
      lat_valid <= 1'b0;
      lat_value <= '0;
      lat_max   <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
      start_q   <= start_nxt;
      lat_valid <= 1'b0;
      if (state == IDLE) begin
        if (cfg_start) begin
          num_q     <= cfg_num_txn;
          gap_q     <= cfg_gap;
          gap_cnt   <= '0;
          started_q <= '0;
          done_q    <= '0;
          inflight  <= '0;
          err       <= 1'b0;
          lat_max   <= '0;
        end
      end else begin
        started_q <= started_nxt;
        done_q    <= done_nxt;
        inflight  <= inflight_nxt;
        gap_cnt   <= gap_nxt;
        if (spurious) err <= 1'b1;
        if (cmpl) begin
          lat_valid <= 1'b1;
          lat_value <= lat_cur;
          if (lat_cur > lat_max) lat_max <= lat_cur;
        end
      end
    end
  end

endmodule
